// File: rtl/pl_run_controller_if.sv
// Write-back observation bundle: retirement, PC and hazard-unit activity
// presented by the CPU pipeline to the run controller.
interface pl_run_controller_if #(
  parameter int ADDR_W = 32
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_pc;
  logic              stall;
  logic              flush;

  modport master (
    output wb_valid, wb_pc, stall, flush
  );

  modport slave (
    input wb_valid, wb_pc, stall, flush
  );
endinterface

// File: rtl/pl_run_controller.sv
// Run controller: sequences CPU reset, detects end/timeout/hang
// from write-back and keeps saturating run statistics.
module pl_run_controller #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] END_ADDR     = 'h34,
  parameter int                RST_CYCLES   = 2,
  parameter int                DRAIN_CYCLES = 4,
  parameter int                MAX_CYCLES   = 4096,
  parameter int                HANG_CYCLES  = 64,
  parameter int                CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  pl_run_controller_if.slave wb,
  output logic               cpu_rst,
  output logic               running,
  output logic               done,
  output logic [1:0]         status,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  localparam int HW = $clog2(HANG_CYCLES + 1);

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_TMO  = 2'd2;
  localparam logic [1:0] ST_HANG = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state;
  logic [RW-1:0]  rst_cnt;
  logic [DW-1:0]  drain_cnt;
  logic [HW-1:0]  idle_cnt;

  logic [CNT_W-1:0] cyc_nx, ret_nx, stl_nx, fls_nx;
  logic [HW-1:0]    idle_nx;
  logic             hit_end, hit_hang, hit_max;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             inc
  );
    return (inc && !(&v)) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    cyc_nx   = sat_inc(cycle_cnt, 1'b1);
    ret_nx   = sat_inc(retired_cnt, wb.wb_valid);
    stl_nx   = sat_inc(stall_cnt, wb.stall);
    fls_nx   = sat_inc(flush_cnt, wb.flush);
    idle_nx  = wb.wb_valid ? '0 : idle_cnt + 1'b1;
    hit_end  = wb.wb_valid && (wb.wb_pc == END_ADDR);
    hit_hang = idle_nx >= HW'(HANG_CYCLES);
    hit_max  = cyc_nx >= CNT_W'(MAX_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cpu_rst     <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      status      <= ST_NONE;
      rst_cnt     <= '0;
      drain_cnt   <= '0;
      idle_cnt    <= '0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RST_HOLD;
            cpu_rst     <= 1'b1;
            done        <= 1'b0;
            status      <= ST_NONE;
            rst_cnt     <= '0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
          end
        end
        S_RST_HOLD: begin
          if (rst_cnt == RW'(RST_CYCLES - 1)) begin
            state    <= S_RUN;
            cpu_rst  <= 1'b0;
            running  <= 1'b1;
            idle_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          cycle_cnt   <= cyc_nx;
          retired_cnt <= ret_nx;
          stall_cnt   <= stl_nx;
          flush_cnt   <= fls_nx;
          idle_cnt    <= idle_nx;
          // End-of-program wins over a hang or budget expiry in the same cycle
          if (hit_end) begin
            status    <= ST_PASS;
            drain_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              state   <= S_DONE;
              cpu_rst <= 1'b1;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if (hit_hang || hit_max) begin
            status  <= hit_hang ? ST_HANG : ST_TMO;
            state   <= S_DONE;
            cpu_rst <= 1'b1;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
        S_DRAIN: begin
          cycle_cnt   <= cyc_nx;
          retired_cnt <= ret_nx;
          stall_cnt   <= stl_nx;
          flush_cnt   <= fls_nx;
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
            state   <= S_DONE;
            cpu_rst <= 1'b1;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_run_controller.sv
// Scoreboard bench: default-parameter instance (a) and a
// 16-cycle-budget instance (b) driven by directed runs.
module tb_pl_run_controller;

  typedef struct {
    logic [1:0] st;
    int         cyc;
    int         ret;
    int         stl;
    int         fls;
  } exp_t;

  logic clk, rst, start_a, start_b;
  logic cpu_rst_a, running_a, done_a;
  logic cpu_rst_b, running_b, done_b;
  logic [1:0]  status_a, status_b;
  logic [31:0] cyc_a, ret_a, stl_a, fls_a;
  logic [31:0] cyc_b, ret_b, stl_b, fls_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;

  pl_run_controller_if #(.ADDR_W(32)) ifa ();
  pl_run_controller_if #(.ADDR_W(32)) ifb ();

  pl_run_controller dut_a (
    .clk(clk), .rst(rst), .start(start_a), .wb(ifa),
    .cpu_rst(cpu_rst_a), .running(running_a), .done(done_a),
    .status(status_a), .cycle_cnt(cyc_a), .retired_cnt(ret_a),
    .stall_cnt(stl_a), .flush_cnt(fls_a)
  );

  pl_run_controller #(.MAX_CYCLES(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .wb(ifb),
    .cpu_rst(cpu_rst_b), .running(running_b), .done(done_b),
    .status(status_b), .cycle_cnt(cyc_b), .retired_cnt(ret_b),
    .stall_cnt(stl_b), .flush_cnt(fls_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation on every rising done.
  always @(negedge clk) begin
    exp_t e;
    if (done_a && !done_a_q) begin
      chk("a.expect_avail", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a.status", 32'(status_a), 32'(e.st));
        chk("a.cycle_cnt", cyc_a, e.cyc);
        chk("a.retired_cnt", ret_a, e.ret);
        chk("a.stall_cnt", stl_a, e.stl);
        chk("a.flush_cnt", fls_a, e.fls);
      end
    end
    if (done_b && !done_b_q) begin
      chk("b.expect_avail", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b.status", 32'(status_b), 32'(e.st));
        chk("b.cycle_cnt", cyc_b, e.cyc);
        chk("b.retired_cnt", ret_b, e.ret);
        chk("b.stall_cnt", stl_b, e.stl);
        chk("b.flush_cnt", fls_b, e.fls);
      end
    end
    done_a_q = done_a;
    done_b_q = done_b;
  end

  task automatic start_run_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_run_b;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget && !done_a; i++) tick();
    chk("a.done_seen", 32'(done_a), 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done_b(input int budget);
    for (int i = 0; i < budget && !done_b; i++) tick();
    chk("b.done_seen", 32'(done_b), 32'd1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ifa.wb_valid = 1'b0; ifa.wb_pc = '0;
    ifa.stall = 1'b0;    ifa.flush = 1'b0;
    ifb.wb_valid = 1'b0; ifb.wb_pc = '0;
    ifb.stall = 1'b0;    ifb.flush = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst.cpu_rst", 32'(cpu_rst_a), 32'd1);
    chk("rst.running", 32'(running_a), 32'd0);
    chk("rst.done", 32'(done_a), 32'd0);
    chk("rst.status", 32'(status_a), 32'd0);
    chk("rst.cycle_cnt", cyc_a, 32'd0);
    rst = 1'b1;
    tick();

    // Start sequencing: cpu_rst held for two cycles
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("hold1.cpu_rst", 32'(cpu_rst_a), 32'd1);
    chk("hold1.running", 32'(running_a), 32'd0);
    tick();
    chk("hold2.cpu_rst", 32'(cpu_rst_a), 32'd1);
    tick();
    chk("run.cpu_rst", 32'(cpu_rst_a), 32'd0);
    chk("run.running", 32'(running_a), 32'd1);
    chk("run.cycle_cnt", cyc_a, 32'd0);
    chk("run.retired_cnt", ret_a, 32'd0);

    // Program 0..0x34 then 4 drain retires (END again); start ignored
    qa.push_back('{st: 2'd1, cyc: 18, ret: 18, stl: 0, fls: 0});
    for (int i = 0; i < 14; i++) begin
      ifa.wb_valid = 1'b1;
      ifa.wb_pc = 32'(i * 4);
      start_a = (i == 5);
      tick();
    end
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifa.wb_pc = 32'h34;
      tick();
    end
    ifa.wb_valid = 1'b0;
    wait_done_a(20);

    // Counters frozen in DONE
    ifa.wb_valid = 1'b1;
    tick(); tick(); tick();
    ifa.wb_valid = 1'b0;
    chk("done.frozen_ret", ret_a, 32'd18);
    chk("done.cpu_rst", 32'(cpu_rst_a), 32'd1);
    chk("done.done", 32'(done_a), 32'd1);

    // Restart from DONE clears counters; then hang with stall/flush
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("restart.done", 32'(done_a), 32'd0);
    chk("restart.cycle_cnt", cyc_a, 32'd0);
    chk("restart.retired_cnt", ret_a, 32'd0);
    chk("restart.status", 32'(status_a), 32'd0);
    tick();
    tick();
    qa.push_back('{st: 2'd3, cyc: 64, ret: 0, stl: 3, fls: 2});
    for (int k = 0; k < 64; k++) begin
      ifa.stall = (k < 3);
      ifa.flush = (k == 1) || (k == 3);
      tick();
    end
    ifa.stall = 1'b0;
    ifa.flush = 1'b0;
    wait_done_a(10);

    // Timeout on the 16-cycle instance
    start_run_b();
    qb.push_back('{st: 2'd2, cyc: 16, ret: 8, stl: 0, fls: 0});
    for (int k = 0; k < 16; k++) begin
      ifb.wb_valid = (k % 2 == 0);
      ifb.wb_pc = 32'h10;
      tick();
    end
    ifb.wb_valid = 1'b0;
    wait_done_b(10);

    // END retire coincides with timeout: PASS wins, drain unaffected
    start_run_b();
    qb.push_back('{st: 2'd1, cyc: 20, ret: 1, stl: 0, fls: 0});
    for (int k = 0; k < 16; k++) begin
      ifb.wb_valid = (k == 15);
      ifb.wb_pc = 32'h34;
      tick();
    end
    ifb.wb_valid = 1'b0;
    wait_done_b(10);

    // Reset mid-run overrides start
    start_run_a();
    ifa.wb_valid = 1'b1;
    ifa.wb_pc = '0;
    for (int k = 0; k < 5; k++) tick();
    ifa.wb_valid = 1'b0;
    chk("mid.retired_cnt", ret_a, 32'd5);
    rst = 1'b0;
    start_a = 1'b1;
    tick();
    chk("mid_rst.cpu_rst", 32'(cpu_rst_a), 32'd1);
    chk("mid_rst.running", 32'(running_a), 32'd0);
    chk("mid_rst.cycle_cnt", cyc_a, 32'd0);
    chk("mid_rst.retired_cnt", ret_a, 32'd0);
    rst = 1'b1;
    start_a = 1'b0;
    tick(); tick(); tick();
    chk("post_rst.running", 32'(running_a), 32'd0);
    chk("post_rst.cpu_rst", 32'(cpu_rst_a), 32'd1);

    chk("a.queue_empty", 32'(qa.size()), 32'd0);
    chk("b.queue_empty", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
